// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data-bus request/grant/response bundle between the LSU and memory
interface lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: funct3-decoded bus access, core stall, load lane extraction
// Optional watchdog on REQ/WAIT enabled by defining LSU_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        access_err,
  lsu_if.master       bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        cmd;
  logic        cmd_we;
  logic        cmd_legal;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;
  logic        we_q;
  logic        err_q;
  logic [2:0]  f3_q;
  logic [1:0]  a_q;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic        timeout;

  assign cmd    = mem_read | mem_write;
  assign cmd_we = mem_write & ~mem_read;

  always_comb begin
    cmd_legal = 1'b1;
    cmd_be    = 4'b0000;
    cmd_wdata = wdata;
    case (funct3)
      3'b000, 3'b100: begin
        cmd_be    = 4'b0001 << addr[1:0];
        cmd_wdata = {4{wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        cmd_be    = 4'b0011 << {addr[1], 1'b0};
        cmd_wdata = {2{wdata[15:0]}};
        cmd_legal = ~addr[0];
      end
      3'b010: begin
        cmd_be    = 4'b1111;
        cmd_legal = (addr[1:0] == 2'b00);
      end
      default: cmd_legal = 1'b0;
    endcase
    // There is no unsigned store; SBU/SHU encodings are rejected.
    if (cmd_we && funct3[2]) cmd_legal = 1'b0;
  end

  assign lane_byte = bus.bus_rdata[{a_q, 3'b000} +: 8];
  assign lane_half = bus.bus_rdata[{a_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = bus.bus_rdata;
    case (f3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_ext = {24'h000000, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_ext = {16'h0000, lane_half};
      default: load_ext = bus.bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] wd_cnt;

  assign timeout = ((state == REQ && !bus.bus_gnt) || (state == WAIT && !bus.bus_rvalid))
                   && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state_next != state && (state_next == REQ || state_next == WAIT)) begin
      wd_cnt <= '0;
    end else if (state == REQ || state == WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  wire [31:0] unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cmd) state_next = cmd_legal ? REQ : DONE;
      REQ: begin
        if (bus.bus_gnt)  state_next = WAIT;
        else if (timeout) state_next = DONE;
      end
      WAIT: begin
        if (bus.bus_rvalid) state_next = DONE;
        else if (timeout)   state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Low in DONE so the core retires the memory instruction at the end of that cycle.
  assign stall       = rst_n & (((state == IDLE) & cmd) | (state == REQ) | (state == WAIT));
  assign rdata_valid = (state == DONE) & ~err_q & ~we_q;
  assign access_err  = (state == DONE) & err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      f3_q          <= 3'b000;
      a_q           <= 2'b00;
      rdata         <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= 4'b0000;
      bus.bus_wdata <= '0;
    end else begin
      state       <= state_next;
      bus.bus_req <= (state_next == REQ);
      if (state == IDLE && cmd) begin
        we_q  <= cmd_we;
        err_q <= ~cmd_legal;
        f3_q  <= funct3;
        a_q   <= addr[1:0];
        if (cmd_legal) begin
          bus.bus_we    <= cmd_we;
          bus.bus_addr  <= {addr[31:2], 2'b00};
          bus.bus_be    <= cmd_be;
          bus.bus_wdata <= cmd_wdata;
        end else begin
          rdata <= '0;
        end
      end
      if (state == WAIT && bus.bus_rvalid && !we_q) rdata <= load_ext;
      if (timeout) begin
        err_q <= 1'b1;
        rdata <= '0;
      end
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the single-cycle datapath and a multi-cycle data bus. It consumes the decoder's `mem_read`, `mem_write` and `funct3`, the ALU result (address) and rs2 (store data). It runs a request/grant/response transaction on the data bus and holds the core with `stall` until the access completes. On loads it returns the loaded value, lane-extracted and sign- or zero-extended, for the `mem_to_reg` writeback mux.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: watchdog limit; used only with `LSU_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: load requested by the current instruction.
- `mem_write` in 1: store requested by the current instruction.
- `funct3` in 3: access size and signedness.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `stall` out 1: hold PC and register file.
- `rdata` out 32: extended load result.
- `rdata_valid` out 1: one-cycle pulse, `rdata` valid.
- `access_err` out 1: one-cycle pulse, access aborted.
- `bus_req` out 1: bus request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word-aligned address (`addr[31:2]`, `2'b00`).
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_gnt` in 1: request accepted this cycle.
- `bus_rvalid` in 1: response/write-ack; `bus_rdata` is valid this cycle.
- `bus_rdata` in 32: read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If `mem_read | mem_write`, register the command: `we = mem_write & ~mem_read` (a load wins if both are set), `funct3`, `addr[1:0]`, bus fields.
  - Legal access: go to REQ.
  - Illegal access: go to DONE with the error flagged. No bus request is issued.
- **REQ**
  - `bus_req` = 1; all bus fields are held stable.
  - `bus_gnt` = 1: go to WAIT.
- **WAIT**
  - `bus_rvalid` = 1: capture the extended result into `rdata` (loads only), then go to DONE.
- **DONE**
  - Lasts one cycle.
  - Pulses `rdata_valid` (load ok) or `access_err` (error).
  - Always returns to IDLE.
  - Does not re-launch, even though the same instruction still presents `mem_read`/`mem_write` this cycle.
- `stall` = `rst_n & ((IDLE & (mem_read|mem_write)) | REQ | WAIT)`. It is combinational and is low in DONE, so the core advances at the end of DONE.
- Access size by `funct3`:
  - 000 LB/SB: `be = 0001 << addr[1:0]`; data `{4{wdata[7:0]}}`.
  - 001 LH/SH: `be = 0011 << {addr[1],1'b0}`; data `{2{wdata[15:0]}}`.
  - 010 LW/SW: `be = 1111`; data `wdata`.
  - 100 LBU, 101 LHU: as 000/001, zero-extended.
- Illegal accesses:
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - `funct3` ∈ {011, 110, 111}.
  - Stores with `funct3` 100/101.
- On error: `rdata` = 0 and the store is suppressed.
- Load extraction uses the registered `addr[1:0]`: the byte is `bus_rdata[8*a +: 8]`, the halfword is `bus_rdata[16*a[1] +: 16]`.

## Timing
- Reset (asynchronous, immediate): state IDLE; `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`, `rdata`, `rdata_valid`, `access_err`, `stall` are all 0.
- Reset mid-transaction abandons the access. `bus_req` drops asynchronously, and no pulse is produced.
- All bus outputs are registered.
- `bus_rvalid` is ignored outside WAIT, including in the grant cycle.
- The bus guarantees `bus_rvalid` comes no earlier than the cycle after `bus_gnt`.
- Minimum access, with grant in the first REQ cycle and `bus_rvalid` one cycle later:
  - C0 IDLE (stall=1), C1 REQ (gnt), C2 WAIT (rvalid), C3 DONE (stall=0, `rdata_valid`=1).
  - 4 cycles total; the instruction retires at the end of C3.
- Illegal access: C0 IDLE (stall=1), C1 DONE (`access_err`=1).
- Back-to-back memory instructions: the next command is accepted in the IDLE cycle that follows DONE.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8+-bit counter clears on entering REQ or WAIT and increments every cycle while in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES` without the awaited `bus_gnt`/`bus_rvalid`, the FSM goes to DONE with `access_err`=1, `bus_req` dropped and `rdata` = 0.
- Not defined: no counter; the FSM waits indefinitely.

## Test plan
- LW, addr 0x100, `bus_gnt` on the first REQ cycle, `bus_rvalid` next with rdata 0xDEADBEEF → `bus_be`=1111, `bus_addr`=0x100, stall for 3 cycles, `rdata`=0xDEADBEEF with `rdata_valid` in cycle 3.
- LB, addr 0x103, `bus_rdata`=0x80112233 → `bus_be`=1000, `rdata`=0xFFFFFF80; LBU at the same address → `rdata`=0x00000080.
- SH, addr 0x102, `wdata`=0x0000ABCD, grant delayed 3 cycles → `bus_req` held with fields stable, `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD, no `rdata_valid`.
- LW, addr 0x101 → no `bus_req` ever, `access_err` pulse in cycle 1, stall for 1 cycle only.
- Reset asserted during WAIT → `bus_req` and `stall` go 0 immediately, no pulses, and a fresh LW after reset completes normally.
- With `LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, `bus_gnt` never asserted → `access_err` 8 cycles after entering REQ, then IDLE.
